// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the CPU front end:
//   - datapath widths (XLEN, IW) and the sequential PC increment (PC_STEP)
//   - the 5-bit opcode type with its named opcodes
//   - opcode categories, taken from the top two opcode bits
//   - the fetch-stage states
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int IW      = 32;
  localparam int PC_STEP = 4;

  typedef logic [4:0] opcode_t;

  // Arithmetic category (00xxx)
  localparam opcode_t SUM  = 5'b00000;
  localparam opcode_t RES  = 5'b00001;
  localparam opcode_t MUL  = 5'b00010;
  localparam opcode_t DIV  = 5'b00011;
  // Transfer category (01xxx)
  localparam opcode_t CAR  = 5'b01000;
  localparam opcode_t ALM  = 5'b01001;
  // Flow-control category (10xxx): jump and conditional branches
  localparam opcode_t SAP  = 5'b10000;
  localparam opcode_t SMAE = 5'b10001;
  localparam opcode_t SMEE = 5'b10010;
  localparam opcode_t SPE  = 5'b10011;

  localparam logic [1:0] CAT_AR = 2'b00;
  localparam logic [1:0] CAT_TD = 2'b01;
  localparam logic [1:0] CAT_CF = 2'b10;

  // BOOT:   first ROM read after reset still in flight, ROM data not valid
  // RUN:    ROM data corresponds to rd_pc_q and is valid
  // BUBBLE: ROM data is from the wrong path after a redirect
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_t;

  // The category of an opcode is simply its two most significant bits.
  function automatic logic [1:0] opcode_category(input opcode_t op);
    return op[4:3];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register holding the instruction handed to decode.
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     load_i     capture valid_i/instr_i/pc_i on this edge
//     squash_i   kill the held instruction (valid only); has priority over load_i
//     valid_i    the incoming instruction is real
//     instr_i    incoming instruction word
//     pc_i       PC of the incoming instruction
//     valid_o    register holds a real instruction
//     instr_o    held instruction word
//     pc_o       PC of the held instruction
module if_id_reg #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int IW   = cpu_pkg::IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            squash_i,
  input  logic            valid_i,
  input  logic [IW-1:0]   instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [IW-1:0]   instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [IW-1:0]   instr_q;
  logic [XLEN-1:0] pc_q;

  // A squash only clears the valid bit; instruction and PC keep their old
  // contents so decode sees stable (but invalid) data during the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (squash_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch plus IF/ID register. Drives a synchronous ROM with one
//   cycle of read latency and hands instructions to decode.
//   Ports:
//     clk, rst        clock and asynchronous active-high reset
//     imem_addr       ROM read address (the current fetch PC)
//     imem_en         ROM clock enable; low freezes the ROM output
//     imem_rdata      ROM data for the address sampled at the last enabled edge
//     stall           decode stall; freezes fetch and IF/ID
//     redirect_valid  taken jump/branch from execute
//     redirect_pc     jump/branch target
//     id_valid        IF/ID holds a real instruction
//     id_instr        instruction in IF/ID
//     id_pc           PC of id_instr
//     id_opcode       opcode field of id_instr, for the control unit
//     id_is_cf        id_instr belongs to the flow-control category
//     fetch_count     number of instructions delivered to decode
module fetch_stage #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              IW       = cpu_pkg::IW,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [IW-1:0]   imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [IW-1:0]   id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_opcode,
  output logic            id_is_cf,
  output logic [31:0]     fetch_count
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d;
  fetch_state_t    state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic            rd_valid;
  logic            advance;

  // The ROM output is only trustworthy once a read on the correct path has
  // completed, which is exactly the RUN state.
  assign rd_valid = (state_q == RUN);
  assign advance  = !stall && !redirect_valid;

  // A redirect must clock the ROM even under stall so the target fetch can
  // start as soon as the stall lifts; the data it returns is discarded.
  assign imem_en   = !stall || redirect_valid;
  assign imem_addr = pc_q;

  // Next-state logic: redirect beats stall, stall beats sequential advance.
  always_comb begin
    pc_d    = pc_q;
    rd_pc_d = rd_pc_q;
    state_d = state_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = BUBBLE;
    end else if (!stall) begin
      pc_d    = pc_q + XLEN'(PC_STEP);
      rd_pc_d = pc_q;
      state_d = RUN;
      count_d = count_q + {31'b0, rd_valid};
    end
  end

  // PC, ROM-tracking state and delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rd_pc_q <= '0;
      state_q <= BOOT;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_pc_q <= rd_pc_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .XLEN (XLEN),
    .IW   (IW)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (advance),
    .squash_i (redirect_valid),
    .valid_i  (rd_valid),
    .instr_i  (imem_rdata),
    .pc_i     (rd_pc_q),
    .valid_o  (id_valid),
    .instr_o  (id_instr),
    .pc_o     (id_pc)
  );

  // Decoded purely from the registered instruction, so no ROM-to-control path.
  assign id_opcode   = id_instr[IW-1:IW-5];
  assign id_is_cf    = (opcode_category(id_opcode) == CAT_CF);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;

  logic [31:0] imemAddr, idInstr, idPc, fetchCount;
  logic        imemEn, idValid, idIsCf;
  logic [4:0]  idOpcode;
  logic [31:0] imemRdata = '0;

  logic [31:0] wImemAddr, wIdInstr, wIdPc, wFetchCount;
  logic        wImemEn, wIdValid, wIdIsCf;
  logic [4:0]  wIdOpcode;
  logic [31:0] wImemRdata = '0;

  int checks = 0;
  int errors = 0;

  // Reference model of what fetch should be doing
  logic [31:0] mPc, mRdPc, mCount;
  logic        mRdValid, mIdValid;
  logic [63:0] expQ[$];

  always #5 clk = ~clk;

  // ROM contents: two fixed words at the start, a scrambled pattern elsewhere.
  function automatic logic [31:0] romData(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0800_0005;
    if (addr == 32'h4) return 32'h1000_0003;
    return 32'hA5A5_0000 ^ (addr * 32'h0009_E377);
  endfunction

  // Synchronous ROMs with clock enable, one per DUT.
  always @(posedge clk) if (imemEn) imemRdata <= romData(imemAddr);
  always @(posedge clk) if (wImemEn) wImemRdata <= romData(wImemAddr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imemAddr), .imem_en(imemEn),
    .imem_rdata(imemRdata), .stall(stall), .redirect_valid(redirectValid),
    .redirect_pc(redirectPc), .id_valid(idValid), .id_instr(idInstr),
    .id_pc(idPc), .id_opcode(idOpcode), .id_is_cf(idIsCf),
    .fetch_count(fetchCount)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst), .imem_addr(wImemAddr), .imem_en(wImemEn),
    .imem_rdata(wImemRdata), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .id_valid(wIdValid), .id_instr(wIdInstr),
    .id_pc(wIdPc), .id_opcode(wIdOpcode), .id_is_cf(wIdIsCf),
    .fetch_count(wFetchCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    mPc = 32'h0; mRdPc = 32'h0; mCount = 32'h0;
    mRdValid = 1'b0; mIdValid = 1'b0;
    expQ.delete();
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, then compare
  // the DUT against the model and pop any delivered instruction.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp);
    logic [63:0] exp;
    stall = s; redirectValid = r; redirectPc = rp;
    #1 checkOutput("imem_en", {31'b0, imemEn}, {31'b0, (!s || r)});
    @(posedge clk);
    if (r) begin
      mPc = rp; mRdValid = 1'b0; mIdValid = 1'b0;
    end else if (!s) begin
      if (mRdValid) begin
        expQ.push_back({mRdPc, romData(mRdPc)});
        mCount = mCount + 32'd1;
      end
      mIdValid = mRdValid;
      mRdPc = mPc; mRdValid = 1'b1; mPc = mPc + 32'd4;
    end
    #1;
    checkOutput("id_valid", {31'b0, idValid}, {31'b0, mIdValid});
    checkOutput("imem_addr", imemAddr, mPc);
    checkOutput("fetch_count", fetchCount, mCount);
    if (!s && !r && idValid && expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput("sb_id_pc", idPc, exp[63:32]);
      checkOutput("sb_id_instr", idInstr, exp[31:0]);
      checkOutput("sb_id_opcode", {27'b0, idOpcode}, {27'b0, exp[31:27]});
      checkOutput("sb_id_is_cf", {31'b0, idIsCf}, {31'b0, (exp[31:30] == 2'b10)});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] savedCount;
    resetModel();
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_id_valid", {31'b0, idValid}, 32'd0);
    checkOutput("reset_imem_addr", imemAddr, 32'h0);
    checkOutput("reset_wrap_addr", wImemAddr, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Boot: two edges before the first instruction reaches decode
    applyStimulus(0, 0, 0);
    checkOutput("boot_e1_valid", {31'b0, idValid}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("boot_e2_valid", {31'b0, idValid}, 32'd1);
    checkOutput("boot_e2_pc", idPc, 32'h0);
    checkOutput("boot_e2_opcode", {27'b0, idOpcode}, 32'd1);
    checkOutput("wrap_e2_pc", wIdPc, 32'hFFFF_FFF8);
    applyStimulus(0, 0, 0);
    checkOutput("boot_e3_pc", idPc, 32'h4);
    checkOutput("boot_e3_opcode", {27'b0, idOpcode}, 32'd2);
    checkOutput("boot_e3_count", fetchCount, 32'd2);
    checkOutput("wrap_e3_pc", wIdPc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0);
    checkOutput("wrap_e4_pc", wIdPc, 32'h0000_0000);
    checkOutput("wrap_e4_valid", {31'b0, wIdValid}, 32'd1);

    // Stall for three cycles while id_pc=8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput("stall_id_pc", idPc, 32'h8);
      checkOutput("stall_addr", imemAddr, 32'h10);
      checkOutput("stall_count", fetchCount, 32'd3);
    end
    applyStimulus(0, 0, 0);
    checkOutput("unstall_pc1", idPc, 32'hC);
    applyStimulus(0, 0, 0);
    checkOutput("unstall_pc2", idPc, 32'h10);

    // Plain redirect: two bubbles, then the target
    savedCount = mCount;
    applyStimulus(0, 1, 32'h40);
    checkOutput("redir_b1_valid", {31'b0, idValid}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("redir_b2_valid", {31'b0, idValid}, 32'd0);
    checkOutput("redir_b2_count", fetchCount, savedCount);
    applyStimulus(0, 0, 0);
    checkOutput("redir_tgt_pc", idPc, 32'h40);
    checkOutput("redir_tgt_instr", idInstr, romData(32'h40));
    checkOutput("redir_tgt_count", fetchCount, savedCount + 32'd1);
    applyStimulus(0, 0, 0);

    // Redirect together with stall: redirect wins, stall then holds the bubble
    applyStimulus(1, 1, 32'h80);
    checkOutput("rs_addr", imemAddr, 32'h80);
    checkOutput("rs_valid", {31'b0, idValid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput("rs_hold_valid", {31'b0, idValid}, 32'd0);
      checkOutput("rs_hold_addr", imemAddr, 32'h80);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rs_tgt_pc", idPc, 32'h80);

    // Misaligned target passes through untouched
    applyStimulus(0, 1, 32'h102);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("misaligned_pc", idPc, 32'h102);

    // Random stalls and occasional redirects against the model
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    {$urandom_range(0, 255), 2'b00});
    end

    // Asynchronous reset between edges
    stall = 1'b0; redirectValid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, idValid}, 32'd0);
    checkOutput("async_rst_addr", imemAddr, 32'h0);
    checkOutput("async_rst_count", fetchCount, 32'd0);
    #1 rst = 1'b0;
    resetModel();
    applyStimulus(0, 0, 0);
    checkOutput("reboot_e1_valid", {31'b0, idValid}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("reboot_e2_valid", {31'b0, idValid}, 32'd1);
    checkOutput("reboot_e2_pc", idPc, 32'h0);
    applyStimulus(0, 0, 0);

    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
